// File: rtl/ram_pkg.sv
// Shared types and helpers for the 3-read/1-write RAM responder.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

  localparam int unsigned MAX_READ_LATENCY = 3;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// One read port: write-first forwarding mux followed by a READ_LATENCY-deep register chain.
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             wa_en,
  input  logic [AW-1:0]    wa_addr,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned STAGES = (READ_LATENCY < 1) ? 1 :
                                   (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                   READ_LATENCY;

  logic [WIDTH-1:0] pipe_d [STAGES];
  logic [WIDTH-1:0] pipe_q [STAGES];

  // wa (debug write) outranks wb (sweep/port write) when both target raddr.
  always_comb begin
    if (wa_en && (wa_addr == raddr)) begin
      pipe_d[0] = wa_data;
    end else if (wb_en && (wb_addr == raddr)) begin
      pipe_d[0] = wb_data;
    end else begin
      pipe_d[0] = mem_rdata;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (rst) begin
        pipe_q[i] <= '0;
      end else begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign rdata = pipe_q[STAGES-1];

endmodule

// File: rtl/ram_3r1w_responder.sv
// Memory-side responder: 3 read ports, 1 write port, debug access, collision flag and clear sweep.
module ram_3r1w_responder
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr_0,
  input  logic [AW-1:0]    raddr_1,
  input  logic [AW-1:0]    raddr_2,
  output logic [WIDTH-1:0] rdata_0,
  output logic [WIDTH-1:0] rdata_1,
  output logic [WIDTH-1:0] rdata_2,
  input  logic [AW-1:0]    waddr_0,
  input  logic [WIDTH-1:0] wdata_0,
  input  logic             wen_0,
  input  logic [AW-1:0]    debug_addr,
  output logic [WIDTH-1:0] debug_data,
  input  logic [AW-1:0]    debug_write_addr,
  input  logic [WIDTH-1:0] debug_write_data,
  input  logic             debug_write_en,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             wr_collision
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ram_state_t       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             collision_q, collision_d;

  logic             dbg_we;
  logic             sweep_we;
  logic             port_ok;
  logic             port_drop;
  logic             port_we;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;

  logic [AW-1:0]    raddr_v  [3];
  logic [WIDTH-1:0] mem_rd_v [3];
  logic [WIDTH-1:0] rdata_v  [3];

  // Write arbitration: debug > sweep > port. Debug and a lower-priority write may
  // both land on one edge when they target different addresses.
  always_comb begin
    dbg_we    = debug_write_en && addr_in_range(32'(debug_write_addr), DEPTH);
    sweep_we  = (state_q == CLEAR) && !rst &&
                !(dbg_we && (debug_write_addr == ptr_q));
    port_ok   = wen_0 && addr_in_range(32'(waddr_0), DEPTH);
    port_drop = port_ok &&
                ((dbg_we && (debug_write_addr == waddr_0)) || (state_q == CLEAR));
    port_we   = port_ok && !port_drop;
    wb_en     = sweep_we || port_we;
    wb_addr   = sweep_we ? ptr_q : waddr_0;
    wb_data   = sweep_we ? '0 : wdata_0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    collision_d = collision_q || port_drop;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      collision_q <= collision_d;
    end
  end

  // Array is never reset; the debug write is issued last so it wins any overlap.
  always_ff @(posedge clk) begin
    if (wb_en) begin
      mem_q[wb_addr] <= wb_data;
    end
    if (dbg_we) begin
      mem_q[debug_write_addr] <= debug_write_data;
    end
  end

  always_comb begin
    raddr_v[0] = raddr_0;
    raddr_v[1] = raddr_1;
    raddr_v[2] = raddr_2;
    for (int unsigned k = 0; k < 3; k++) begin
      mem_rd_v[k] = addr_in_range(32'(raddr_v[k]), DEPTH) ? mem_q[raddr_v[k]] : '0;
    end
    debug_data = addr_in_range(32'(debug_addr), DEPTH) ? mem_q[debug_addr] : '0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rd
    ram_read_pipe #(
      .WIDTH        (WIDTH),
      .AW           (AW),
      .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .raddr     (raddr_v[g]),
      .mem_rdata (mem_rd_v[g]),
      .wa_en     (dbg_we),
      .wa_addr   (debug_write_addr),
      .wa_data   (debug_write_data),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rdata     (rdata_v[g])
    );
  end

  assign rdata_0      = rdata_v[0];
  assign rdata_1      = rdata_v[1];
  assign rdata_2      = rdata_v[2];
  assign clear_busy   = (state_q == CLEAR);
  assign wr_collision = collision_q;

endmodule

// File: tb/tb_ram_3r1w_responder.sv
// Scoreboard bench: stimulus queues expected values with a due cycle, a negedge monitor checks them.
module tb_ram_3r1w_responder;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [AW-1:0]    raddr_0, raddr_1, raddr_2, waddr_0, debug_addr, debug_write_addr;
  logic [WIDTH-1:0] wdata_0, debug_write_data;
  logic             wen_0, debug_write_en, clear_req;

  logic [WIDTH-1:0] a_rdata_0, a_rdata_1, a_rdata_2, a_debug_data;
  logic             a_clear_busy, a_wr_collision;
  logic [WIDTH-1:0] b_rdata_0, b_rdata_1, b_rdata_2, b_debug_data;
  logic             b_clear_busy, b_wr_collision;

  ram_3r1w_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_0(a_rdata_0), .rdata_1(a_rdata_1), .rdata_2(a_rdata_2),
    .waddr_0(waddr_0), .wdata_0(wdata_0), .wen_0(wen_0),
    .debug_addr(debug_addr), .debug_data(a_debug_data),
    .debug_write_addr(debug_write_addr), .debug_write_data(debug_write_data),
    .debug_write_en(debug_write_en), .clear_req(clear_req),
    .clear_busy(a_clear_busy), .wr_collision(a_wr_collision)
  );

  ram_3r1w_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_0(b_rdata_0), .rdata_1(b_rdata_1), .rdata_2(b_rdata_2),
    .waddr_0(waddr_0), .wdata_0(wdata_0), .wen_0(wen_0),
    .debug_addr(debug_addr), .debug_data(b_debug_data),
    .debug_write_addr(debug_write_addr), .debug_write_data(debug_write_data),
    .debug_write_en(debug_write_en), .clear_req(clear_req),
    .clear_busy(b_clear_busy), .wr_collision(b_wr_collision)
  );

  typedef struct {
    int unsigned      due;
    int               sel;
    logic [WIDTH-1:0] exp;
    string            name;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc++;

  // sel: 0..2 rdata (latency 1), 3..5 rdata (latency 3), 6 debug_data, 7 wr_collision,
  // 8 clear_busy, 9 wr_collision (latency 3), 10 debug_data (latency 3)
  function automatic logic [WIDTH-1:0] dut_val(input int sel);
    case (sel)
      0:       return a_rdata_0;
      1:       return a_rdata_1;
      2:       return a_rdata_2;
      3:       return b_rdata_0;
      4:       return b_rdata_1;
      5:       return b_rdata_2;
      6:       return a_debug_data;
      7:       return {31'b0, a_wr_collision};
      8:       return {31'b0, a_clear_busy};
      9:       return {31'b0, b_wr_collision};
      default: return b_debug_data;
    endcase
  endfunction

  task automatic expect_at(input int unsigned due, input int sel, input logic [WIDTH-1:0] v,
                           input string nm);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    int i;
    logic [WIDTH-1:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        got = dut_val(sb[i].sel);
        checks++;
        if (got !== sb[i].exp) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].name, cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: check expired at cycle %0d, expected %0d", sb[i].name, cyc, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_wr(input int unsigned addr, input logic [WIDTH-1:0] data);
    debug_write_en   = 1'b1;
    debug_write_addr = AW'(addr);
    debug_write_data = data;
    tick();
    debug_write_en   = 1'b0;
  endtask

  logic [WIDTH-1:0] pre [12];

  initial begin
    pre = '{6, 1, 2, 3, 7, 4, 8, 5, 9, 2, 1, 7};
    rst = 1'b1;
    raddr_0 = '0; raddr_1 = '0; raddr_2 = '0;
    waddr_0 = '0; wdata_0 = '0; wen_0 = 1'b0;
    debug_addr = '0; debug_write_addr = '0; debug_write_data = '0; debug_write_en = 1'b0;
    clear_req = 1'b0;
    tick();

    // preload under reset
    for (int unsigned i = 0; i < DEPTH; i++) begin
      dbg_wr(i, (i < 12) ? pre[i] : 32'(100 + i));
    end
    rst = 1'b0;
    expect_at(cyc, 0, 0, "reset_rdata0");
    expect_at(cyc, 3, 0, "reset_rdata0_l3");
    expect_at(cyc, 7, 0, "reset_collision");
    expect_at(cyc, 8, 0, "reset_busy");
    for (int unsigned i = 0; i < 12; i++) begin
      debug_addr = AW'(i);
      expect_at(cyc, 6, pre[i], "preload_debug");
      tick();
    end

    // basic reads, both latencies
    raddr_0 = 5'd3; raddr_1 = 5'd4; raddr_2 = 5'd11;
    expect_at(cyc + 1, 0, 3, "read_p0");
    expect_at(cyc + 1, 1, 7, "read_p1");
    expect_at(cyc + 1, 2, 7, "read_p2");
    expect_at(cyc + 3, 3, 3, "read_p0_l3");
    expect_at(cyc + 3, 4, 7, "read_p1_l3");
    expect_at(cyc + 3, 5, 7, "read_p2_l3");
    tick();
    raddr_0 = 5'd0; raddr_1 = 5'd5; raddr_2 = 5'd10;
    expect_at(cyc + 1, 0, 6, "read2_p0");
    expect_at(cyc + 1, 1, 4, "read2_p1");
    expect_at(cyc + 1, 2, 1, "read2_p2");
    expect_at(cyc + 3, 5, 1, "read2_p2_l3");
    tick();
    raddr_0 = '0; raddr_1 = '0; raddr_2 = '0;
    tick(); tick(); tick();

    // port write forwarded to a same-cycle read
    wen_0 = 1'b1; waddr_0 = 5'd12; wdata_0 = 71; raddr_0 = 5'd12;
    expect_at(cyc + 1, 0, 71, "fwd_port_write");
    expect_at(cyc + 3, 3, 71, "fwd_port_write_l3");
    tick();
    wen_0 = 1'b0; debug_addr = 5'd12;
    expect_at(cyc, 6, 71, "port_write_landed");
    tick();

    // debug and port writes to different addresses both land, no flag
    dbg_wr(14, 44);
    debug_write_en = 1'b1; debug_write_addr = 5'd14; debug_write_data = 44;
    wen_0 = 1'b1; waddr_0 = 5'd15; wdata_0 = 55;
    tick();
    debug_write_en = 1'b0; wen_0 = 1'b0;
    debug_addr = 5'd14;
    expect_at(cyc, 6, 44, "dual_write_dbg");
    expect_at(cyc, 7, 0, "dual_write_no_flag");
    tick();
    debug_addr = 5'd15;
    expect_at(cyc, 6, 55, "dual_write_port");
    tick();

    // debug vs port collision on the same address
    wen_0 = 1'b1; waddr_0 = 5'd13; wdata_0 = 5;
    debug_write_en = 1'b1; debug_write_addr = 5'd13; debug_write_data = 83;
    raddr_1 = 5'd13;
    expect_at(cyc + 1, 1, 83, "fwd_debug_wins");
    expect_at(cyc + 3, 4, 83, "fwd_debug_wins_l3");
    tick();
    wen_0 = 1'b0; debug_write_en = 1'b0; raddr_1 = '0;
    debug_addr = 5'd13;
    expect_at(cyc, 6, 83, "collide_mem13");
    expect_at(cyc, 7, 1, "collide_flag");
    expect_at(cyc, 9, 1, "collide_flag_l3");
    for (int i = 0; i < 5; i++) tick();
    expect_at(cyc, 7, 1, "collide_flag_sticky");
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_at(cyc, 7, 0, "flag_cleared_by_rst");
    tick();

    // clear sweep
    clear_req = 1'b1;
    expect_at(cyc, 8, 0, "busy_before_sweep");
    tick();
    clear_req = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      expect_at(cyc, 8, 1, "busy_during_sweep");
      wen_0 = (k == 22);
      waddr_0 = 5'd5; wdata_0 = 99;
      clear_req = (k == 15);
      debug_write_en = (k == 10);
      debug_write_addr = 5'd30; debug_write_data = 77;
      if (k == 20) begin
        raddr_2 = 5'd20; raddr_1 = 5'd25;
        expect_at(cyc + 1, 2, 0, "fwd_sweep_write");
        expect_at(cyc + 1, 1, 125, "read_during_sweep");
        expect_at(cyc + 3, 5, 0, "fwd_sweep_write_l3");
        expect_at(cyc + 3, 4, 125, "read_during_sweep_l3");
      end
      if (k == 24) expect_at(cyc, 7, 1, "sweep_drop_flag");
      tick();
    end
    wen_0 = 1'b0; clear_req = 1'b0; debug_write_en = 1'b0;
    raddr_1 = '0; raddr_2 = '0;
    expect_at(cyc, 8, 0, "busy_after_sweep");
    for (int unsigned i = 0; i < DEPTH; i++) begin
      debug_addr = AW'(i);
      expect_at(cyc, 6, 0, "swept_zero");
      expect_at(cyc, 10, 0, "swept_zero_l3");
      tick();
    end

    // reset mid-sweep
    for (int unsigned i = 0; i < DEPTH; i++) dbg_wr(i, 32'(200 + i));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    expect_at(cyc, 8, 1, "busy_before_abort");
    tick();
    rst = 1'b0;
    expect_at(cyc, 8, 0, "busy_after_abort");
    tick();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      debug_addr = AW'(i);
      expect_at(cyc, 6, (i < 10) ? 32'd0 : 32'(200 + i), "abort_contents");
      tick();
    end

    for (int k = 0; k < 5; k++) tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked, expected %0d", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
